// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// CTRL bit positions and the active-high hex-to-segment table.
package hex_display_pkg;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_BLINK_MASK = 4'd1;
    localparam logic [3:0] ADDR_VALUE      = 4'd2;
    localparam logic [3:0] ADDR_STATUS     = 4'd3;
    localparam int         ADDR_DIGIT0     = 8;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_DECODE     = 1;
    localparam int CTRL_LAMP_TEST  = 2;
    localparam int CTRL_BRIGHT_LSB = 8;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_display_timebase.sv
// Free-running blink prescaler/phase and PWM counter; unaffected by CTRL.
module hex_display_timebase
    import hex_display_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BLINK_HZ    = 2,
    parameter int PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                blink_phase,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    localparam int HALF_RAW = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] presc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (presc == LAST) begin
                presc       <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                presc <= presc + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment display controller with decode, blink and PWM.
// Lamp test is built only when HEX_DISPLAY_LAMP_TEST_EN is defined.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BLINK_HZ    = 2,
    parameter int PWM_BITS    = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic [7*NUM_DIGITS-1:0] hex_segments
);

    localparam logic [6:0] PIN_BLANK = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    logic                         ctrl_enable;
    logic                         ctrl_decode;
    logic                         lamp_test;
    logic [PWM_BITS-1:0]          brightness;
    logic [NUM_DIGITS-1:0]        blink_mask;
    logic [NUM_DIGITS-1:0][6:0]   digits;
    logic [NUM_DIGITS-1:0][6:0]   next_seg;
    logic [31:0]                  rd_data;
    logic                         blink_phase;
    logic [PWM_BITS-1:0]          pwm_cnt;
    logic                         pwm_on;

    hex_display_timebase #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BLINK_HZ   (BLINK_HZ),
        .PWM_BITS   (PWM_BITS)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .blink_phase(blink_phase),
        .pwm_cnt    (pwm_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            ctrl_decode <= 1'b0;
            lamp_test   <= 1'b0;
            brightness  <= '0;
            blink_mask  <= '0;
            digits      <= '0;
        end else if (avs_write) begin
            if (avs_address == ADDR_CTRL) begin
                ctrl_enable <= avs_writedata[CTRL_ENABLE];
                ctrl_decode <= avs_writedata[CTRL_DECODE];
`ifdef HEX_DISPLAY_LAMP_TEST_EN
                lamp_test   <= avs_writedata[CTRL_LAMP_TEST];
`endif
                brightness  <= avs_writedata[CTRL_BRIGHT_LSB +: PWM_BITS];
            end
            if (avs_address == ADDR_BLINK_MASK)
                blink_mask <= avs_writedata[NUM_DIGITS-1:0];
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (avs_address == ADDR_VALUE)
                    digits[i] <= {3'b000, avs_writedata[4*i +: 4]};
                else if (avs_address == 4'(ADDR_DIGIT0 + i))
                    digits[i] <= avs_writedata[6:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            avs_address == ADDR_CTRL: begin
                rd_data[CTRL_ENABLE]                 = ctrl_enable;
                rd_data[CTRL_DECODE]                 = ctrl_decode;
                rd_data[CTRL_LAMP_TEST]              = lamp_test;
                rd_data[CTRL_BRIGHT_LSB +: PWM_BITS] = brightness;
            end
            avs_address == ADDR_BLINK_MASK:
                rd_data[NUM_DIGITS-1:0] = blink_mask;
            avs_address == ADDR_STATUS:
                rd_data[0] = blink_phase;
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (avs_address == 4'(ADDR_DIGIT0 + i))
                        rd_data[6:0] = digits[i];
            end
        endcase
    end

    // Old contents are returned on a same-cycle read/write since rd_data
    // is sampled from the pre-edge register values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_data;
    end

    assign pwm_on = (brightness == '1) | (pwm_cnt < brightness);

    always_comb begin
        logic [6:0] seg;
        logic [6:0] lit_seg;
        seg      = SEG_BLANK;
        lit_seg  = SEG_BLANK;
        next_seg = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg = ctrl_decode ? hex7(digits[i][3:0]) : digits[i];
            lit_seg = (ctrl_enable & pwm_on & ~(blink_mask[i] & blink_phase))
                      ? seg : SEG_BLANK;
            if (lamp_test)
                lit_seg = SEG_ALL;
            next_seg[i] = (ACTIVE_LOW != 0) ? ~lit_seg : lit_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hex_segments <= {NUM_DIGITS{PIN_BLANK}};
        else
            hex_segments <= next_seg;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl against a cycle-count based model.
module tb_hex_display_ctrl;

    localparam int ND = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [41:0] hex_segments;

    int checks = 0;
    int errors = 0;
    int k;

    bit         m_en, m_dec, m_lamp;
    int         m_bright;
    logic [5:0] m_mask;
    logic [6:0] m_dig [ND];
    logic [6:0] hex7_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                  7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .CLK_FREQ_HZ(1000),
        .BLINK_HZ   (100),
        .PWM_BITS   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .hex_segments (hex_segments)
    );

    // Edges since the last reset release; timebase state before edge n is
    // phase=((n-1)/5)%2, pwm=(n-1)%16.
    always @(posedge clk or posedge reset)
        if (reset) k <= 0;
        else       k <= k + 1;

    function automatic logic [41:0] model_seg(int c);
        logic [41:0] r;
        logic [6:0]  seg;
        bit          phase, pwm_on, lit;
        r = '0;
        phase  = ((c / 5) % 2) == 1;
        pwm_on = (m_bright == 15) || ((c % 16) < m_bright);
        for (int i = 0; i < ND; i++) begin
            seg = m_dec ? hex7_tab[m_dig[i][3:0]] : m_dig[i];
            lit = m_en && pwm_on && !(m_mask[i] && phase);
            if (!lit) seg = 7'h00;
            if (m_lamp) seg = 7'h7F;
            r[7*i +: 7] = ~seg;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(int a, int c);
        logic [31:0] r;
        r = '0;
        if (a == 0) begin
            r[0] = m_en;
            r[1] = m_dec;
            r[2] = m_lamp;
            r[11:8] = m_bright[3:0];
        end else if (a == 1) begin
            r[5:0] = m_mask;
        end else if (a == 3) begin
            r[0] = ((c / 5) % 2) == 1;
        end else if (a >= 8 && a < 8 + ND) begin
            r[6:0] = m_dig[a-8];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_en = 0; m_dec = 0; m_lamp = 0; m_bright = 0; m_mask = '0;
        for (int i = 0; i < ND; i++) m_dig[i] = '0;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(int a, logic [31:0] d);
        @(negedge clk);
        avs_address = 4'(a);
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        if (a == 0) begin
            m_en = d[0];
            m_dec = d[1];
`ifdef HEX_DISPLAY_LAMP_TEST_EN
            m_lamp = d[2];
`endif
            m_bright = int'(d[11:8]);
        end else if (a == 1) begin
            m_mask = d[5:0];
        end else if (a == 2) begin
            for (int i = 0; i < ND; i++) m_dig[i] = {3'b000, d[4*i +: 4]};
        end else if (a >= 8 && a < 8 + ND) begin
            m_dig[a-8] = d[6:0];
        end
    endtask

    task automatic rd(int a, string tag);
        @(negedge clk);
        avs_address = 4'(a);
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        check(tag, avs_readdata, model_read(a, k - 1));
    endtask

    task automatic run_check(int n, string tag);
        repeat (n) begin
            @(negedge clk);
            check(tag, hex_segments, model_seg(k - 1));
        end
    endtask

    task automatic count_lit(int n, output int lit);
        lit = 0;
        repeat (n) begin
            @(negedge clk);
            check("pwm_model", hex_segments, model_seg(k - 1));
            if (hex_segments[13:7] != 7'h7F) lit++;
        end
    endtask

    initial begin
        int lit;
        logic [31:0] held;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_check(2, "idle_blank");

        wr(8, 32'h0000_0012);
        rd(8, "pre_reset_rd");

        // Reset mid-run with no clock edge in between
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_segments", hex_segments, 42'h3FF_FFFF_FFFF);
        check("rst_readdata", avs_readdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 16; a++) rd(a, "rst_reg_read");

        // Decode
        wr(0, 32'h0F03);
        wr(2, 32'h00A5);
        @(negedge clk);
        check("dec_d0", hex_segments[6:0], 7'h12);
        check("dec_d1", hex_segments[13:7], 7'h08);
        for (int i = 2; i < ND; i++)
            check("dec_dn", hex_segments[7*i +: 7], 7'h40);
        check("dec_model", hex_segments, model_seg(k - 1));
        rd(2, "value_rd0");

        // Raw mode, readback, out-of-range digit
        wr(0, 32'h0F01);
        wr(11, 32'h49);
        @(negedge clk);
        check("raw_d3", hex_segments[27:21], 7'h36);
        rd(11, "raw_rd11");
        held = avs_readdata;
        run_check(2, "raw_model");
        check("rd_held", avs_readdata, held);
        wr(14, 32'h7F);
        rd(14, "rd_addr14");

        // Same-cycle read and write returns the old value
        @(negedge clk);
        avs_address = 4'd11;
        avs_writedata = 32'h12;
        avs_read = 1'b1;
        avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        avs_write = 1'b0;
        check("rw_old", avs_readdata, 32'h49);
        m_dig[3] = 7'h12;
        rd(11, "rw_new");

        // Blink
        wr(1, 32'h01);
        run_check(22, "blink");
        rd(3, "status_a");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rd(3, "status_b");
        rd(1, "mask_rd");
        wr(1, 32'h00);

        // Brightness
        wr(2, 32'h0000_0080);
        wr(0, 32'h0403);
        count_lit(16, lit);
        check("bright4", 64'(lit), 64'd4);
        wr(0, 32'h0003);
        count_lit(16, lit);
        check("bright0", 64'(lit), 64'd0);
        wr(0, 32'h0F03);
        count_lit(16, lit);
        check("bright15", 64'(lit), 64'd16);

        // Lamp test
        wr(0, 32'h0004);
        @(negedge clk);
`ifdef HEX_DISPLAY_LAMP_TEST_EN
        check("lamp_on", hex_segments, 42'h0);
`else
        check("lamp_off", hex_segments, 42'h3FF_FFFF_FFFF);
`endif
        run_check(3, "lamp_model");
        rd(0, "lamp_ctrl_rd");

        // Randomized writes and reads against the model
        repeat (60) begin
            int a;
            logic [31:0] d;
            a = int'($urandom_range(0, 15));
            d = $urandom;
            if (a == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            wr(a, d);
            run_check(int'($urandom_range(1, 4)), "rand_seg");
            rd(int'($urandom_range(0, 15)), "rand_rd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised Avalon-MM seven-segment display controller; successor to the fixed 3-digit hex outputs. Drives NUM_DIGITS digits. Supports per-digit raw-segment or hex-decode mode, per-digit blink and global PWM brightness. Sits on the Qsys system bus; segment outputs export as a conduit to the board pins.

Parameters:
NUM_DIGITS, 6, digit count, legal range 1..8
CLK_FREQ_HZ, 50000000, clk frequency
BLINK_HZ, 2, blink rate; blink half-period is CLK_FREQ_HZ/(2*BLINK_HZ) cycles
PWM_BITS, 4, brightness resolution
ACTIVE_LOW, 1, 1 = segment pins low-active (board default)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
avs_address  in  4  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, fixed latency 1
hex_segments  out  7*NUM_DIGITS  digit i at bits [7i+6:7i], bit0=a..bit6=g

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset); all flops clear on reset assertion.
- Register map:
  - 0 CTRL: [0] enable, [1] decode, [2] lamp_test (macro only), [PWM_BITS+7:8] brightness.
  - 1 BLINK_MASK: [NUM_DIGITS-1:0].
  - 2 VALUE: write-only; nibble i is loaded into DIGIT i [3:0] and DIGIT i [6:4] is cleared; reads 0.
  - 3 STATUS: read-only; [0] blink_phase.
  - 8+i DIGIT i: [6:0].
- Unmapped addresses and i >= NUM_DIGITS: read 0, writes ignored. Unused bits read 0.
- Reads: avs_readdata is registered, valid the cycle after avs_read, and held until the next read. On a same-cycle read and write to the same address, the read returns the old value.
- Segment pipeline, per digit:
  - seg = decode ? HEX7[digit[3:0]] : digit[6:0].
  - lit = enable & pwm_on & ~(blink_mask[i] & blink_phase).
  - out = lit ? seg : 0.
  - Invert the result when ACTIVE_LOW.
- hex_segments is registered: a write accepted at edge N is visible after edge N+1.
- Timebase:
  - Prescaler counts 0..HALF-1, then wraps and toggles blink_phase.
  - HALF < 1 is clamped to 1.
  - Prescaler and blink_phase free-run regardless of enable.
- PWM:
  - Free-running PWM_BITS counter.
  - pwm_on = (brightness == all-ones) | (pwm_cnt < brightness).
  - brightness 0 gives a fully dark display.
- Writing BLINK_MASK does not reset the prescaler or blink_phase.
- Reset values:
  - All registers 0, pwm_cnt 0, blink_phase 0, avs_readdata 0.
  - hex_segments all-blank: all ones when ACTIVE_LOW, else zeros.
- Reset mid-operation blanks the display asynchronously. Outputs stay blank until CTRL is rewritten.

Optional Feature:
- Macro HEX_DISPLAY_LAMP_TEST_EN.
- Defined: CTRL[2] forces every segment of every digit lit, overriding enable, decode, blink and PWM. CTRL[2] is readable.
- Undefined: CTRL[2] is ignored and reads 0; no lamp-test logic is built.

Decomposition:
- Package hex_display_pkg holds:
  - Register address constants and CTRL bit positions.
  - SEG_BLANK.
  - 16-entry HEX7 table, active-high: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Sub-module hex_display_timebase contains the prescaler, blink_phase and PWM counter. Outputs: blink_phase, pwm_cnt.

Test Plan (CLK_FREQ_HZ=1000, BLINK_HZ=100 so HALF=5; NUM_DIGITS=6; PWM_BITS=4; ACTIVE_LOW=1):
- Reset check: assert reset mid-run, with no clock edge -> hex_segments = 42'h3FFFFFFFFFF immediately; readdata 0; after release, all registers read 0.
- Decode: write CTRL=0x0F03, then VALUE=0x00A5 -> digit0 segments ~7'h6D, digit1 ~7'h77, digits 2..5 ~7'h3F, one cycle after write.
- Raw mode: CTRL=0x0F01, DIGIT3=0x49 -> digit3 = ~7'h49. Readback of address 11 returns 0x49 one cycle after avs_read. Address 14 (DIGIT 6, beyond NUM_DIGITS) reads 0.
- Blink: BLINK_MASK=0x01 -> digit0 alternates lit/blank every 5 cycles; other digits steady; STATUS[0] tracks the phase.
- Brightness: CTRL brightness=4 -> each digit lit exactly 4 of every 16 cycles. Brightness=0 -> always blank. Brightness=15 -> always lit.
- Lamp test (macro defined): CTRL=0x0004 -> all 42 bits = 0 despite enable=0. Undefined: same write leaves display blank and CTRL reads 0.
